td4_sequencer: RTL
==================

// Module: td4_sequencer
// PURPOSE
//  Program counter, instruction decode and run control for the TD4 core; sits directly upstream of
//  the register file and drives its active-low load strobes plus the ALU source select and immediate.
//  Fetches one 8-bit instruction per committed cycle from an asynchronous 16x8 program ROM, resolves
//  JMP/JNC against the carry flag, and gates execution with an IDLE/RUN/HALT FSM (single-step, halt).
// PARAMETERS
//  RESET_PC          4'h0  PC value loaded on reset
//  CNT_W             8     width of retired-instruction counter
//  HALT_ON_SELF_JMP  1     1: a taken jump to its own address enters HALT; 0: loops forever
// PORTS
//  clk         in   1      clock, all state on posedge
//  rst         in   1      asynchronous, active-high reset
//  run_en      in   1      level: free-run request
//  step        in   1      1-cycle pulse (synchronous): execute one instruction while IDLE
//  rom_addr    out  4      = pc (registered)
//  rom_data    in   8      instruction at rom_addr, same cycle ([7:4] opcode, [3:0] imm)
//  c_flag      in   1      current carry flag from register file
//  load_n      out  3      [0]=A [1]=B [2]=OUT, active-low write strobes to register file
//  alu_sel     out  2      ALU operand: 00 A, 01 B, 10 IN port, 11 zero
//  imm         out  4      = rom_data[3:0], always passed through
//  flag_we     out  1      1: datapath writes ALU carry into C; 0: datapath recirculates C
//  state       out  2      00 IDLE, 01 RUN, 10 HALT
//  halted      out  1      state==HALT
//  retired     out  CNT_W  committed-instruction count, saturating
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=IDLE, retired=0; load_n=3'b111, flag_we=0 while rst high.
//  commit = (state==RUN) | (state==IDLE & step). HALT never commits.
//  Decode (combinational from rom_data, qualified by commit; no commit -> load_n=111, flag_we=0):
//   0000 ADD A,Im: ld A, sel A  | 0101 ADD B,Im: ld B, sel B | 0011 MOV A,Im: ld A, sel 0
//   0111 MOV B,Im: ld B, sel 0  | 0001 MOV A,B: ld A, sel B  | 0100 MOV B,A: ld B, sel A
//   0010 IN A: ld A, sel IN     | 0110 IN B: ld B, sel IN    | 1001 OUT B: ld OUT, sel B
//   1011 OUT Im: ld OUT, sel 0  | 1111 JMP Im: no ld, sel 0  | 1110 JNC Im: no ld, sel 0
//   1000/1010/1100/1101 illegal: NOP, no load, flag_we=0, PC+1 (retired still counts).
//  flag_we=1 on every committed legal opcode (incl. jumps; carry of 0+imm is 0).
//  Next PC on commit: JMP -> imm; JNC -> imm if c_flag==0 else pc+1; else pc+1 (4-bit wrap F->0).
//   c_flag sampled is the pre-commit value (the flag of the previous instruction).
//  No commit: pc, retired unchanged.
//  FSM (registered, posedge):
//   IDLE: run_en=1 -> RUN (entry cycle commits only if step); else stay.
//   RUN : commits every cycle; run_en=0 sampled -> IDLE (that cycle still commits).
//   any committing state: taken jump with imm==pc and HALT_ON_SELF_JMP=1 -> HALT (jump still
//    commits; pc stays). Halt has priority over RUN->IDLE.
//   HALT: sticky until rst; run_en/step ignored.
//  step while RUN: ignored. step and run_en rising together in IDLE: one commit, then RUN.
//  retired: +1 per commit, holds at all-ones.
//  rst asserted mid-instruction: state cleared immediately; strobes forced inactive same cycle.
// STRUCTURE
//  Shared include td4_defs.vh: opcode localparams, ALU_SEL_* encodings, FSM state encodings.
//  Sub-module td4_decode: purely combinational opcode -> {load_n, alu_sel, is_jmp, is_jnc, legal}.
//  td4_sequencer owns pc, FSM, counter and commit gating.
// TESTING
//  Reset: rst=1 mid-run with run_en=1 -> pc=0, state=IDLE, load_n=111, retired=0 same cycle.
//  Step: IDLE, ROM[0]=8'h35 (MOV A,5), step pulse -> one cycle load_n=110, sel=11, imm=5; pc 0->1.
//  JNC: ROM[3]=8'hE9, c_flag=1 -> pc=4; c_flag=0 -> pc=9; flag_we=1 both cases.
//  Wrap: run from pc=F with ROM[F]=8'h01 -> next pc=0, retired increments by 1.
//  Halt: ROM[6]=8'hF6, run_en=1 -> jump commits, state=HALT next cycle; step/run_en -> no change.
//  Illegal+saturate: ROM filled 8'h80, CNT_W=8, run 300 cycles -> load_n stays 111, retired=255.

Source files
------------

// File: rtl/td4_sequencer_pkg.sv
// Purpose : shared opcode, ALU operand-select and FSM encodings for the TD4 sequencer.
// Latency : n/a (definitions only).
// Backpressure: n/a.
// Contents: opcode_e, ALU_SEL_* operand selects, state_e run-control states,
//           dec_t decoder result record.
package td4_sequencer_pkg;

   typedef enum logic [3:0] {
      OP_ADD_A_IM = 4'b0000,
      OP_MOV_A_B  = 4'b0001,
      OP_IN_A     = 4'b0010,
      OP_MOV_A_IM = 4'b0011,
      OP_MOV_B_A  = 4'b0100,
      OP_ADD_B_IM = 4'b0101,
      OP_IN_B     = 4'b0110,
      OP_MOV_B_IM = 4'b0111,
      OP_OUT_B    = 4'b1001,
      OP_OUT_IM   = 4'b1011,
      OP_JNC_IM   = 4'b1110,
      OP_JMP_IM   = 4'b1111
   } opcode_e;

   localparam logic [1:0] ALU_SEL_A    = 2'b00;
   localparam logic [1:0] ALU_SEL_B    = 2'b01;
   localparam logic [1:0] ALU_SEL_IN   = 2'b10;
   localparam logic [1:0] ALU_SEL_ZERO = 2'b11;

   // Active-low register-file strobes: bit0=A, bit1=B, bit2=OUT.
   localparam logic [2:0] LD_NONE = 3'b111;
   localparam logic [2:0] LD_A    = 3'b110;
   localparam logic [2:0] LD_B    = 3'b101;
   localparam logic [2:0] LD_OUT  = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_e;

   typedef struct packed {
      logic [2:0] load_n;
      logic [1:0] alu_sel;
      logic       is_jmp;
      logic       is_jnc;
      logic       legal;
   } dec_t;

endpackage

// File: rtl/td4_sequencer_decode.sv
// Purpose : purely combinational TD4 opcode decoder (ungated by commit).
// Latency : 0 cycles, combinational.
// Backpressure: none; the caller masks strobes when nothing commits.
// Ports   : opcode_i [3:0] instruction opcode; dec_o decoded record
//           {load_n, alu_sel, is_jmp, is_jnc, legal}.
module td4_decode
   import td4_sequencer_pkg::*;
(
   input  logic [3:0] opcode_i,
   output dec_t       dec_o
);

   always_comb begin
      dec_o         = '0;
      dec_o.load_n  = LD_NONE;
      dec_o.alu_sel = ALU_SEL_ZERO;
      dec_o.legal   = 1'b1;
      unique case (opcode_i)
         OP_ADD_A_IM: begin dec_o.load_n = LD_A;   dec_o.alu_sel = ALU_SEL_A;    end
         OP_MOV_A_B : begin dec_o.load_n = LD_A;   dec_o.alu_sel = ALU_SEL_B;    end
         OP_IN_A    : begin dec_o.load_n = LD_A;   dec_o.alu_sel = ALU_SEL_IN;   end
         OP_MOV_A_IM: begin dec_o.load_n = LD_A;   dec_o.alu_sel = ALU_SEL_ZERO; end
         OP_MOV_B_A : begin dec_o.load_n = LD_B;   dec_o.alu_sel = ALU_SEL_A;    end
         OP_ADD_B_IM: begin dec_o.load_n = LD_B;   dec_o.alu_sel = ALU_SEL_B;    end
         OP_IN_B    : begin dec_o.load_n = LD_B;   dec_o.alu_sel = ALU_SEL_IN;   end
         OP_MOV_B_IM: begin dec_o.load_n = LD_B;   dec_o.alu_sel = ALU_SEL_ZERO; end
         OP_OUT_B   : begin dec_o.load_n = LD_OUT; dec_o.alu_sel = ALU_SEL_B;    end
         OP_OUT_IM  : begin dec_o.load_n = LD_OUT; dec_o.alu_sel = ALU_SEL_ZERO; end
         OP_JMP_IM  : dec_o.is_jmp = 1'b1;
         OP_JNC_IM  : dec_o.is_jnc = 1'b1;
         // 1000/1010/1100/1101 execute as a NOP that still advances the PC.
         default    : dec_o.legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/td4_sequencer.sv
// Purpose : TD4 program counter, instruction decode gating and IDLE/RUN/HALT run control.
// Latency : strobes combinational from rom_data_i in the committing cycle; pc/state/retired update on posedge.
// Backpressure: none; execution is paced only by run_en_i / step_i, HALT blocks all commits until reset.
// Ports   : clk_i, rst_i (async, active-high); run_en_i level run request; step_i single-step pulse;
//           rom_addr_o/rom_data_i program ROM; c_flag_i carry flag; load_n_o, alu_sel_o, imm_o,
//           flag_we_o register-file controls; state_o, halted_o, retired_o status.
module td4_sequencer
   import td4_sequencer_pkg::*;
#(
   parameter logic [3:0] RESET_PC         = 4'h0,
   parameter int         CNT_W            = 8,
   parameter bit         HALT_ON_SELF_JMP = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             run_en_i,
   input  logic             step_i,
   output logic [3:0]       rom_addr_o,
   input  logic [7:0]       rom_data_i,
   input  logic             c_flag_i,
   output logic [2:0]       load_n_o,
   output logic [1:0]       alu_sel_o,
   output logic [3:0]       imm_o,
   output logic             flag_we_o,
   output logic [1:0]       state_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] retired_o
);

   logic [3:0]       pc_q, pc_d;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   dec_t dec;
   logic commit;
   logic taken;
   logic self_halt;

   td4_decode u_decode (
      .opcode_i (rom_data_i[7:4]),
      .dec_o    (dec)
   );

   // rst_i gates commit so strobes go inactive in the same cycle reset rises,
   // even if step_i is held high during reset.
   assign commit    = !rst_i && ((state_q == ST_RUN) || ((state_q == ST_IDLE) && step_i));
   // c_flag_i is the flag left by the previous instruction; this one has not written it yet.
   assign taken     = commit && (dec.is_jmp || (dec.is_jnc && !c_flag_i));
   assign self_halt = HALT_ON_SELF_JMP && taken && (rom_data_i[3:0] == pc_q);

   // PC and retired counter.
   always_comb begin
      pc_d      = pc_q;
      retired_d = retired_q;
      if (commit) begin
         pc_d = taken ? rom_data_i[3:0] : pc_q + 4'd1;
         if (!(&retired_q)) retired_d = retired_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q      <= RESET_PC;
         retired_q <= '0;
      end else begin
         pc_q      <= pc_d;
         retired_q <= retired_d;
      end
   end

   // FSM: state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM: next state. A self-jump halt outranks the RUN->IDLE drop.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (self_halt)     state_d = ST_HALT;
            else if (run_en_i) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (self_halt)      state_d = ST_HALT;
            else if (!run_en_i) state_d = ST_IDLE;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs.
   always_comb begin
      load_n_o  = commit ? dec.load_n : LD_NONE;
      flag_we_o = commit && dec.legal;
      alu_sel_o = dec.alu_sel;
      halted_o  = (state_q == ST_HALT);
      state_o   = state_q;
   end

   assign rom_addr_o = pc_q;
   assign imm_o      = rom_data_i[3:0];
   assign retired_o  = retired_q;

endmodule
